// File: rtl/clk_gate_ctrl.sv
// N-channel clock-gating controller: per-channel OFF/WAKE/ON/DRAIN FSM drives a
// glitch-free latch gate, with wake-up delay, idle auto-gating and test enable.
module clk_gate_ctrl #(
  parameter int NCH      = 4,
  parameter int CNT_W    = 8,
  parameter int WAKE_DLY = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               te,
  input  logic [NCH-1:0]     en,
  input  logic [NCH-1:0]     wake,
  input  logic [NCH-1:0]     busy,
  input  logic [CNT_W-1:0]   idle_thr,
  output logic [NCH-1:0]     clkout,
  output logic [NCH-1:0]     ack,
  output logic [NCH-1:0]     sleep,
  output logic [2*NCH-1:0]   state_dbg
);

  // Handshake: en is a level request; ack is high only while the gated clock
  // is running and stable (ON). en may drop at any time; ack then drops next cycle.
  typedef enum logic [1:0] {S_OFF = 2'd0, S_WAKE = 2'd1, S_ON = 2'd2, S_DRAIN = 2'd3} state_t;

  localparam logic [3:0] WAKE_LD = 4'(WAKE_DLY);

  logic [CNT_W-1:0] thr_m1;
  assign thr_m1 = idle_thr - {{(CNT_W-1){1'b0}}, 1'b1};

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    state_t           state_q, state_d;
    logic [3:0]       wcnt_q, wcnt_d;
    logic [CNT_W-1:0] icnt_q, icnt_d;
    logic             sleep_q, sleep_d;
    logic             gate_on, ack_c, gate_lat, auto_hit;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        state_q <= S_OFF;
        wcnt_q  <= '0;
        icnt_q  <= '0;
        sleep_q <= 1'b0;
      end else begin
        state_q <= state_d;
        wcnt_q  <= wcnt_d;
        icnt_q  <= icnt_d;
        sleep_q <= sleep_d;
      end
    end

    // ">=" rather than "==" so a lowered threshold gates on the next idle cycle.
    assign auto_hit = (idle_thr != '0) && (icnt_q >= thr_m1);

    always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      icnt_d  = icnt_q;
      sleep_d = sleep_q;
      if (!en[g] || wake[g]) sleep_d = 1'b0;
      case (state_q)
        S_OFF: begin
          icnt_d = '0;
          if (en[g] && (!sleep_q || wake[g])) begin
            state_d = S_WAKE;
            wcnt_d  = WAKE_LD;
          end
        end
        S_WAKE: begin
          icnt_d = '0;
          if (!en[g])              state_d = S_DRAIN;
          else if (wcnt_q == 4'd0) state_d = S_ON;
          else                     wcnt_d  = wcnt_q - 4'd1;
        end
        S_ON: begin
          if (!en[g]) begin
            state_d = S_DRAIN;
            icnt_d  = '0;
          end else if (busy[g]) begin
            icnt_d = '0;
          end else if (auto_hit) begin
            state_d = S_DRAIN;
            sleep_d = 1'b1;
            icnt_d  = '0;
          end else if (icnt_q != '1) begin
            icnt_d = icnt_q + 1'b1;
          end
        end
        S_DRAIN: begin
          icnt_d = '0;
          if (!busy[g]) state_d = S_OFF;
        end
        default: state_d = S_OFF;
      endcase
    end

    always_comb begin
      gate_on = (state_q != S_OFF);
      ack_c   = (state_q == S_ON);
    end

    // Latch is transparent only while clk is low, so a high phase is never cut short.
    always_latch begin
      if (!clk) gate_lat <= gate_on | te;
    end

    assign clkout[g]            = gate_lat & clk;
    assign ack[g]               = ack_c;
    assign sleep[g]             = sleep_q;
    assign state_dbg[2*g +: 2]  = state_q;
  end

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Directed bench for clk_gate_ctrl: vector table on channel 0 plus hand-written
// sequences for test enable, drain with busy, and reset during ON.
module tb_clk_gate_ctrl;
  localparam int NCH = 4;
  localparam int CNT_W = 8;
  localparam int WAKE_DLY = 2;

  logic             clk;
  logic             rst_n;
  logic             te;
  logic [NCH-1:0]   en, wake, busy;
  logic [CNT_W-1:0] idle_thr;
  logic [NCH-1:0]   clkout, ack, sleep;
  logic [2*NCH-1:0] state_dbg;

  int checks;
  int failures;
  logic [2:0] exp_q[$];

  clk_gate_ctrl #(.NCH(NCH), .CNT_W(CNT_W), .WAKE_DLY(WAKE_DLY)) dut (
    .clk(clk), .rst_n(rst_n), .te(te), .en(en), .wake(wake), .busy(busy),
    .idle_thr(idle_thr), .clkout(clkout), .ack(ack), .sleep(sleep),
    .state_dbg(state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic       en;
    logic       wake;
    logic       busy;
    logic [7:0] thr;
    logic       ack;
    logic       slp;
    logic       clk0;
  } vec_t;

  vec_t vecs[32];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Returns 1 ns after a rising edge (inside the high phase).
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Samples a clkout bit early and late in the high phase; both must match.
  task automatic check_clk(input string name, input int idx, input logic exp);
    check({name, "_early"}, 32'(clkout[idx]), 32'(exp));
    #3;
    check({name, "_late"}, 32'(clkout[idx]), 32'(exp));
  endtask

  task automatic set_vec(input int i, input logic e, input logic w, input logic b,
                         input logic [7:0] t, input logic a, input logic s, input logic c);
    vecs[i].en = e; vecs[i].wake = w; vecs[i].busy = b; vecs[i].thr = t;
    vecs[i].ack = a; vecs[i].slp = s; vecs[i].clk0 = c;
  endtask

  initial begin
    logic [2:0] exp_v;
    checks = 0;
    failures = 0;

    //                 en w  b  thr  ack slp clk
    set_vec( 0, 1, 0, 0, 0, 0, 0, 0);
    set_vec( 1, 1, 0, 0, 0, 0, 0, 1);
    set_vec( 2, 1, 0, 0, 0, 0, 0, 1);
    set_vec( 3, 1, 0, 0, 0, 1, 0, 1);
    set_vec( 4, 1, 0, 0, 5, 1, 0, 1);
    set_vec( 5, 1, 0, 0, 5, 1, 0, 1);
    set_vec( 6, 1, 0, 0, 5, 1, 0, 1);
    set_vec( 7, 1, 0, 0, 5, 1, 0, 1);
    set_vec( 8, 1, 0, 0, 5, 0, 1, 1);
    set_vec( 9, 1, 0, 0, 5, 0, 1, 1);
    set_vec(10, 1, 0, 0, 5, 0, 1, 0);
    set_vec(11, 1, 0, 0, 5, 0, 1, 0);
    set_vec(12, 1, 1, 0, 5, 0, 0, 0);
    set_vec(13, 1, 0, 0, 5, 0, 0, 1);
    set_vec(14, 1, 0, 0, 5, 0, 0, 1);
    set_vec(15, 1, 0, 0, 5, 1, 0, 1);
    set_vec(16, 1, 0, 0, 0, 1, 0, 1);
    set_vec(17, 1, 0, 0, 0, 1, 0, 1);
    set_vec(18, 1, 0, 0, 0, 1, 0, 1);
    set_vec(19, 1, 0, 0, 2, 0, 1, 1);
    set_vec(20, 1, 0, 0, 2, 0, 1, 1);
    set_vec(21, 0, 1, 0, 2, 0, 0, 0);
    set_vec(22, 1, 0, 0, 2, 0, 0, 0);
    set_vec(23, 1, 0, 0, 2, 0, 0, 1);
    set_vec(24, 1, 0, 0, 2, 0, 0, 1);
    set_vec(25, 1, 0, 0, 2, 1, 0, 1);
    set_vec(26, 1, 0, 0, 2, 1, 0, 1);
    set_vec(27, 1, 0, 1, 2, 1, 0, 1);
    set_vec(28, 1, 0, 0, 2, 1, 0, 1);
    set_vec(29, 0, 0, 0, 2, 0, 0, 1);
    set_vec(30, 0, 0, 0, 2, 0, 0, 1);
    set_vec(31, 0, 0, 0, 2, 0, 0, 0);

    // Reset with te=1: all gated clocks open, ack/sleep low.
    rst_n = 1'b0; te = 1'b1; en = '0; wake = '0; busy = '0; idle_thr = '0;
    step();
    step();
    check("rst_te_clkout", 32'(clkout), 32'hF);
    check("rst_ack", 32'(ack), 32'h0);
    check("rst_sleep", 32'(sleep), 32'h0);
    rst_n = 1'b1;
    step();
    check("off_te_clkout", 32'(clkout), 32'hF);
    check("off_te_ack", 32'(ack), 32'h0);
    // Drop te mid high phase: current pulse completes, then clocks stop.
    te = 1'b0;
    #2;
    check("te_drop_hold", 32'(clkout), 32'hF);
    step();
    check("te_drop_stop", 32'(clkout), 32'h0);
    check("off_state", 32'(state_dbg), 32'h0);

    // Channel 0 vector table.
    for (int i = 0; i < 32; i++) begin
      en = {3'b000, vecs[i].en};
      wake = {3'b000, vecs[i].wake};
      busy = {3'b000, vecs[i].busy};
      idle_thr = vecs[i].thr;
      exp_q.push_back({vecs[i].ack, vecs[i].slp, vecs[i].clk0});
      step();
      exp_v = exp_q.pop_front();
      check($sformatf("v%0d_ack0", i), 32'(ack[0]), 32'(exp_v[2]));
      check($sformatf("v%0d_sleep0", i), 32'(sleep[0]), 32'(exp_v[1]));
      check($sformatf("v%0d_clk0", i), 32'(clkout[0]), 32'(exp_v[0]));
      check($sformatf("v%0d_others", i), 32'({clkout[3:1], ack[3:1]}), 32'h0);
    end

    // Channel 1: en falls while busy stays high for three cycles.
    en = 4'b0010; wake = '0; busy = '0; idle_thr = '0;
    repeat (4) step();
    check("ch1_ack_on", 32'(ack[1]), 32'h1);
    en = 4'b0000; busy = 4'b0010;
    step();
    check("ch1_ack_drop", 32'(ack[1]), 32'h0);
    check_clk("ch1_drain_a1", 1, 1'b1);
    step();
    check_clk("ch1_drain_a2", 1, 1'b1);
    step();
    check_clk("ch1_drain_a3", 1, 1'b1);
    busy = '0;
    step();
    check_clk("ch1_drain_a4", 1, 1'b1);
    step();
    check_clk("ch1_closed", 1, 1'b0);
    check("ch1_state_off", 32'(state_dbg[3:2]), 32'h0);

    // Channel 2: reset asserted while ON with busy high.
    en = 4'b0100; busy = 4'b0100;
    repeat (4) step();
    check("ch2_ack_on", 32'(ack[2]), 32'h1);
    rst_n = 1'b0;
    step();
    check("ch2_rst_ack", 32'(ack[2]), 32'h0);
    check("ch2_rst_sleep", 32'(sleep[2]), 32'h0);
    check_clk("ch2_rst_full_pulse", 2, 1'b1);
    step();
    check_clk("ch2_rst_closed", 2, 1'b0);
    rst_n = 1'b1;
    step();
    check("ch2_rewake_state", 32'(state_dbg[5:4]), 32'h1);
    check_clk("ch2_rewake_clk0", 2, 1'b0);
    step();
    check_clk("ch2_rewake_clk1", 2, 1'b1);
    check("ch2_rewake_ack0", 32'(ack[2]), 32'h0);
    step();
    step();
    check("ch2_rewake_ack1", 32'(ack[2]), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
